// File: rtl/booth4_recoder_seq.sv
// Sequential radix-4 Booth recoder: takes a signed multiplier over valid/ready
// and streams one Booth triplet (with digit value, index and last flag) per beat.
module booth4_recoder_seq #(
  parameter int N  = 8,
  parameter int D  = N / 2,
  parameter int IW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_mult,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    out_ctr,
  output logic [2:0]    out_digit,
  output logic [IW-1:0] out_idx,
  output logic          out_last
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [N:0]    sr_reg, sr_next, sr_shift;
  logic [IW-1:0] idx_reg, idx_next;
  logic          run;
  logic          last;

  // Arithmetic right shift by one Booth digit (two bits), sign-filled from SR[N].
  genvar gi;
  generate
    for (gi = 0; gi <= N; gi++) begin : g_shift
      if (gi <= N - 2) begin : g_move
        assign sr_shift[gi] = sr_reg[gi+2];
      end else begin : g_fill
        assign sr_shift[gi] = sr_reg[N];
      end
    end
  endgenerate

  assign run  = (state_reg == RUN);
  assign last = (idx_reg == IW'(D - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    idx_next   = idx_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sr_next    = {in_mult, 1'b0};
            idx_next   = '0;
            state_next = RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (last) begin
              state_next = IDLE;
            end else begin
              sr_next  = sr_shift;
              idx_next = idx_reg + IW'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs come only from registered state; gated to zero outside RUN.
  assign in_ready  = !run;
  assign out_valid = run;
  assign out_ctr   = run ? sr_reg[2:0] : 3'b000;
  assign out_idx   = run ? idx_reg : '0;
  assign out_last  = run && last;

  always_comb begin
    out_digit = 3'b000;
    case (out_ctr)
      3'b001, 3'b010: out_digit = 3'b001;
      3'b011:         out_digit = 3'b010;
      3'b100:         out_digit = 3'b110;
      3'b101, 3'b110: out_digit = 3'b111;
      default:        out_digit = 3'b000;
    endcase
  end

endmodule
